flash_loader: RTL and testbench

FLASH_LOADER -- requirements
Module: flash_loader

---
 rtl/flash_loader_pkg.sv | 14 +
 rtl/flash_loader_spi_master_byte.sv | 85 ++++++++
 rtl/flash_loader.sv | 139 +++++++++++++
 tb/tb_flash_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// Shared definitions for the SPI flash boot loader.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    FINISH,
    DONE
  } state_t;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;

endpackage

// File: rtl/flash_loader_spi_master_byte.sv
// Mode-0 SPI byte shifter with back-to-back chaining: a start seen while done is
// high queues the next byte so SCLK runs without a gap across byte boundaries.
module spi_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] tx_next;
  logic [6:0] rx_shift;
  logic       chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_byte  <= 8'h00;
      div_cnt  <= 8'h00;
      bit_cnt  <= 3'd0;
      tx_shift <= 8'h00;
      tx_next  <= 8'h00;
      rx_shift <= 7'h00;
      chain    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          tx_shift <= tx_byte;
          div_cnt  <= DIV_LOAD;
          bit_cnt  <= 3'd0;
          chain    <= 1'b0;
        end
      end else begin
        if (done && start) begin
          chain   <= 1'b1;
          tx_next <= tx_byte;
        end
        if (div_cnt != 8'h00) begin
          div_cnt <= div_cnt - 8'd1;
        end else begin
          div_cnt <= DIV_LOAD;
          sclk    <= ~sclk;
          if (!sclk) begin
            rx_shift <= {rx_shift[5:0], miso};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte <= {rx_shift, miso};
              done    <= 1'b1;
            end
          end else if (bit_cnt == 3'd0) begin
            // falling edge after the 8th sample: continue with the queued byte or park low
            if (chain) begin
              tx_shift <= tx_next;
              chain    <= 1'b0;
            end else begin
              busy     <= 1'b0;
              tx_shift <= 8'h00;
            end
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign mosi = tx_shift[7];

endmodule

// File: rtl/flash_loader.sv
// Boot loader: reads LOAD_LEN bytes from SPI flash with a READ command and writes
// them to SRAM, holding booting high until the last write completes.
//   state  | meaning
//   IDLE   | after reset, selects flash and starts the command
//   CMD    | shifting out read opcode and 24-bit address
//   DATA   | streaming bytes in, one SRAM write per byte
//   FINISH | SCLK stopped, waiting for last write pulse to end
//   DONE   | flash deselected, system released (terminal)
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [17:0] RAM_BASE   = 18'h00000,
  parameter logic [17:0] LOAD_LEN   = 18'h10000,
  parameter int          WE_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ss,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ram_we_b,
  output logic [17:0] ram_a,
  output logic [7:0]  ram_din,
  output logic        booting,
  output logic        done
);

  localparam logic [17:0] LAST_BYTE = LOAD_LEN - 18'd1;
  localparam logic [11:0] WE_LOAD   = 12'(WE_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_busy;
  logic        spi_done;
  logic [1:0]  cmd_idx;
  logic [17:0] byte_cnt;
  logic [11:0] we_cnt;
  logic        addr_bump;

  spi_master_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_spi (
    .clk    (clk),
    .reset  (reset),
    .start  (spi_start),
    .tx_byte(spi_tx),
    .miso   (miso),
    .sclk   (sclk),
    .mosi   (mosi),
    .busy   (spi_busy),
    .done   (spi_done),
    .rx_byte(ram_din)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    spi_start  = 1'b0;
    spi_tx     = 8'h00;
    case (state)
      IDLE: begin
        state_next = CMD;
        spi_start  = 1'b1;
        spi_tx     = SPI_READ_CMD;
      end
      CMD: begin
        if (spi_done) begin
          spi_start = 1'b1;
          case (cmd_idx)
            2'd0:    spi_tx = FLASH_BASE[23:16];
            2'd1:    spi_tx = FLASH_BASE[15:8];
            2'd2:    spi_tx = FLASH_BASE[7:0];
            default: state_next = DATA;
          endcase
        end
      end
      DATA: begin
        if (spi_done) begin
          if (byte_cnt == LAST_BYTE) state_next = FINISH;
          else                       spi_start  = 1'b1;
        end
      end
      FINISH: begin
        if (ram_we_b && !spi_busy) state_next = DONE;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss        <= 1'b1;
      booting   <= 1'b1;
      done      <= 1'b0;
      ram_we_b  <= 1'b1;
      ram_a     <= 18'h00000;
      cmd_idx   <= 2'd0;
      byte_cnt  <= 18'h00000;
      we_cnt    <= 12'h000;
      addr_bump <= 1'b0;
    end else begin
      ss        <= !(state_next inside {CMD, DATA, FINISH});
      done      <= (state_next == DONE);
      booting   <= (state_next != DONE);
      addr_bump <= 1'b0;
      if (state == IDLE) begin
        ram_a    <= RAM_BASE;
        cmd_idx  <= 2'd0;
        byte_cnt <= 18'h00000;
      end
      if (state == CMD && spi_done) cmd_idx <= cmd_idx + 2'd1;
      if (state == DATA && spi_done) begin
        ram_we_b <= 1'b0;
        we_cnt   <= WE_LOAD;
        byte_cnt <= byte_cnt + 18'd1;
      end else if (!ram_we_b) begin
        if (we_cnt == 12'h000) begin
          ram_we_b  <= 1'b1;
          addr_bump <= 1'b1;
        end else begin
          we_cnt <= we_cnt - 12'd1;
        end
      end
      // advance one cycle after the strobe rises so address holds across its trailing edge
      if (addr_bump) ram_a <= ram_a + 18'd1;
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader with a behavioural SPI flash model.
module tb_flash_loader;

  localparam int          CLK_DIV    = 2;
  localparam logic [23:0] FLASH_BASE = 24'h123456;
  localparam logic [17:0] RAM_BASE   = 18'h3FFFE;
  localparam logic [17:0] LOAD_LEN   = 18'd4;
  localparam int          WE_CYCLES  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ss, sclk, mosi, miso, ram_we_b, booting, done;
  logic [17:0] ram_a;
  logic [7:0]  ram_din;

  always #5 clk = ~clk;

  flash_loader #(
    .CLK_DIV(CLK_DIV), .FLASH_BASE(FLASH_BASE), .RAM_BASE(RAM_BASE),
    .LOAD_LEN(LOAD_LEN), .WE_CYCLES(WE_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .ram_we_b(ram_we_b), .ram_a(ram_a), .ram_din(ram_din),
    .booting(booting), .done(done)
  );

  typedef struct {
    logic [7:0]  flash_byte;
    logic [17:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t       vec [4];
  logic [7:0] flash_mem [4];
  int         checks = 0;
  int         errors = 0;

  // flash: data bits start after the 32 command/address clocks
  int fl_n = 0;
  int bi;
  always @(posedge sclk or posedge ss) begin
    if (ss) fl_n <= 0;
    else    fl_n <= fl_n + 1;
  end
  always_comb begin
    miso = 1'b0;
    bi   = fl_n - 32;
    if (fl_n >= 32 && fl_n < 64) miso = flash_mem[bi[4:3]][3'd7 - bi[2:0]];
  end

  int          cyc = 0;
  int          rise_n, first_rise, ss_fall, ss_rise, boot_fall, last_rise;
  int          per_min, per_max, pw, pw_min, pw_max, wr_n, stab_err, data_mosi;
  logic [31:0] cmd_word;
  logic [17:0] wr_a [8];
  logic [7:0]  wr_d [8];
  logic        p_sclk = 1'b0, p_we = 1'b1, p_ss = 1'b1, p_boot = 1'b1;
  logic [17:0] p_a = '0;
  logic [7:0]  p_d = '0;

  task automatic clear_mon();
    rise_n = 0; first_rise = -1; ss_fall = -1; ss_rise = -1; boot_fall = -1;
    last_rise = 0; per_min = 999; per_max = 0; pw = 0; pw_min = 999; pw_max = 0;
    wr_n = 0; stab_err = 0; data_mosi = 0; cmd_word = '0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (p_ss && !ss) ss_fall = cyc;
      if (!p_ss && ss) ss_rise = cyc;
      if (p_boot && !booting) boot_fall = cyc;
      if (!p_sclk && sclk) begin
        if (rise_n == 0) first_rise = cyc;
        else begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        if (rise_n < 32) cmd_word = {cmd_word[30:0], mosi};
        else if (mosi) data_mosi++;
        rise_n++;
      end
      if (p_we && !ram_we_b) begin
        pw = 1;
        if (ram_a !== p_a || ram_din !== p_d) stab_err++;
        if (wr_n < 8) begin
          wr_a[wr_n] = ram_a;
          wr_d[wr_n] = ram_din;
        end
        wr_n++;
      end else if (!p_we) begin
        if (ram_a !== p_a || ram_din !== p_d) stab_err++;
        if (!ram_we_b) pw++;
        else begin
          if (pw < pw_min) pw_min = pw;
          if (pw > pw_max) pw_max = pw;
        end
      end
    end
    p_sclk = sclk; p_we = ram_we_b; p_ss = ss; p_boot = booting; p_a = ram_a; p_d = ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_and_check(input string tag);
    for (int i = 0; i < 3000 && done !== 1'b1; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_booting"}, 32'(booting), 0);
    chk({tag, "_ss_end"}, 32'(ss), 1);
    chk({tag, "_sclk_end"}, 32'(sclk), 0);
    chk({tag, "_cmd_word"}, cmd_word, 32'h03123456);
    chk({tag, "_rises"}, rise_n, 64);
    chk({tag, "_first_rise"}, first_rise - ss_fall, 2);
    chk({tag, "_per_min"}, per_min, 4);
    chk({tag, "_per_max"}, per_max, 4);
    chk({tag, "_writes"}, wr_n, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_wr%0d_addr", tag, k), 32'(wr_a[k]), 32'(vec[k].exp_addr));
      chk($sformatf("%s_wr%0d_data", tag, k), 32'(wr_d[k]), 32'(vec[k].exp_data));
    end
    chk({tag, "_we_min"}, pw_min, 3);
    chk({tag, "_we_max"}, pw_max, 3);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_data_mosi"}, data_mosi, 0);
    chk({tag, "_boot_vs_ss"}, boot_fall, ss_rise);
  endtask

  initial begin
    vec[0] = '{8'hA5, 18'h3FFFE, 8'hA5};
    vec[1] = '{8'h5A, 18'h3FFFF, 8'h5A};
    vec[2] = '{8'h00, 18'h00000, 8'h00};
    vec[3] = '{8'hFF, 18'h00001, 8'hFF};
    for (int i = 0; i < 4; i++) flash_mem[i] = vec[i].flash_byte;
    clear_mon();

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ss", 32'(ss), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_we", 32'(ram_we_b), 1);
    chk("rst_ram_a", 32'(ram_a), 0);
    chk("rst_ram_din", 32'(ram_din), 0);
    chk("rst_booting", 32'(booting), 1);
    chk("rst_done", 32'(done), 0);
    @(negedge clk); #1 reset = 1'b0;
    run_and_check("run1");

    repeat (40) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 1);
    chk("hold_rises", rise_n, 64);
    chk("hold_writes", wr_n, 4);

    // restart, then abort during the second data byte's write
    reset = 1'b1;
    repeat (3) @(posedge clk);
    clear_mon();
    @(negedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3000 && wr_n < 2; i++) @(posedge clk);
    #2;
    chk("mid_writes_seen", wr_n, 2);
    chk("mid_we_low", 32'(ram_we_b), 0);
    reset = 1'b1;
    #1;
    chk("abort_ss", 32'(ss), 1);
    chk("abort_booting", 32'(booting), 1);
    chk("abort_we", 32'(ram_we_b), 1);
    chk("abort_sclk", 32'(sclk), 0);
    chk("abort_ram_a", 32'(ram_a), 0);
    repeat (3) @(posedge clk);
    clear_mon();
    @(negedge clk); #1 reset = 1'b0;
    run_and_check("run2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
